// File: rtl/md_unit_pkg.sv
// Shared encodings and defaults for the md_unit multiply/divide unit.
// Defining MD_MADD_EN enables the MADD (op 6) accumulate operation.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and therefore stall the pipe.
  function automatic logic md_is_long_op(input logic [2:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD);
`endif
    return r;
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational arithmetic for md_unit: produces the {hi,lo} value to be
// written when a multi-cycle op completes. MADD path exists only with MD_MADD_EN.
module md_alu
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] hilo_next
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn_div;
  logic        div_zero;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // One unsigned divider serves both DIV and DIVU: signed operands are
  // reduced to magnitudes and the signs reapplied afterwards. This also
  // yields 0x80000000 rem 0 for the 0x80000000 / -1 overflow case.
  always_comb begin
    sgn_div  = (op == MD_DIV);
    div_zero = (b == 32'd0);
    dvd_mag  = (sgn_div && a[31]) ? (32'd0 - a) : a;
    dvs_mag  = (sgn_div && b[31]) ? (32'd0 - b) : b;
    if (div_zero) begin
      dvs_mag = 32'd1;
    end
    q_mag = dvd_mag / dvs_mag;
    r_mag = dvd_mag % dvs_mag;
    quot  = (sgn_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    rem   = (sgn_div && a[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    hilo_next = {hi, lo};
    case (op)
      MD_MULT:  hilo_next = prod_s;
      MD_MULTU: hilo_next = prod_u;
      MD_DIV,
      MD_DIVU: begin
        if (!div_zero) begin
          hilo_next = {rem, quot};
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  hilo_next = {hi, lo} + prod_s;
`endif
      default:  hilo_next = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, IDLE/BUSY sequencer and
// stall request. Build with MD_MADD_EN defined to accept MADD (op 6).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      hilo_next;
  logic             accept;
  logic             finish;

  md_alu u_alu (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .hi        (hi_q),
    .lo        (lo_q),
    .hilo_next (hilo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && start && md_is_long_op(op);
    finish  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only at acceptance; HI/LO stay at their old values
  // until the completing edge, so MFHI/MFLO see pre-op values while busy.
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      op_d  = op;
      cnt_d = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (finish) begin
        hi_d = hilo_next[63:32];
        lo_d = hilo_next[31:0];
      end
    end else if (start && (op == MD_MTHI)) begin
      hi_d = a;
    end else if (start && (op == MD_MTLO)) begin
      lo_d = a;
    end
  end

  always_comb begin
    busy      = (state_q == BUSY);
    stall_req = busy | (start & md_is_long_op(op));
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal results plus
// randomized traffic compared every cycle against a behavioural model.
module tb_md_unit;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_seen;
  logic last_stall;

  // Behavioural model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  md_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic long_op(input logic [2:0] o);
`ifdef MD_MADD_EN
    return (o <= 3'd3) || (o == 3'd6);
`else
    return (o <= 3'd3);
`endif
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, y, h, l);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = {h, l};
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: if (y != 0) begin sq = sx / sy; sr = sx % sy; r = {sr[31:0], sq[31:0]}; end
      3'd3: if (y != 0) begin uq = ux / uy; ur = ux % uy; r = {ur[31:0], uq[31:0]}; end
      3'd6: r = {h, l} + 64'(sx * sy);
      default: r = {h, l};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_left = 0; m_res = '0;
  endtask

  task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] x, y);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_res;
    end else if (s) begin
      if (long_op(o)) begin
        m_left = (o == 3'd2 || o == 3'd3) ? DIV_C : MULT_C;
        m_res  = ref_result(o, x, y, m_hi, m_lo);
      end else if (o == 3'd4) begin
        m_hi = x;
      end else if (o == 3'd5) begin
        m_lo = x;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against model, then advance model.
  task automatic cycle(input logic s, input logic [2:0] o, input logic [31:0] x, y);
    logic exp_stall;
    @(negedge clk);
    start = s; op = o; a = x; b = y;
    #1;
    exp_stall = (m_left > 0) || (s && long_op(o));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
    if (busy === 1'b1) busy_seen++;
    last_stall = stall_req;
    @(posedge clk);
    model_edge(s, o, x, y);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (m_left > 0 && guard < 100) begin
      cycle(1'b0, 3'd0, $urandom, $urandom);
      guard++;
    end
    if (m_left > 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: model still busy after %0d cycles", guard);
    end
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y);
    busy_seen = 0;
    cycle(1'b1, o, x, y);
    wait_done();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // MULT 0xFFFFFFFF x 2
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("mult_busy_cycles", busy_seen, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_busy_cycles", busy_seen, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    cycle(1'b1, 3'd5, 32'h1234, 32'd0);
    run_op(3'd2, 32'd5, 32'd0);
    chk("div0_busy_cycles", busy_seen, 32'd10);
    chk("div0_lo", lo, 32'h0000_1234);
    chk("div0_hi", hi, 32'hFFFF_FFFF);

    // DIVU with MTHI attempted while busy
    busy_seen = 0;
    cycle(1'b1, 3'd3, 32'd100, 32'd7);
    cycle(1'b0, 3'd0, 32'd0, 32'd0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0);
    cycle(1'b1, 3'd4, 32'hAAAA, 32'd0);
    chk("mthi_busy_stall", {31'd0, last_stall}, 32'd1);
    wait_done();
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    cycle(1'b1, 3'd4, 32'hAAAA, 32'd0);
    chk("mthi_stall", {31'd0, last_stall}, 32'd0);
    #1;
    chk("mthi_hi", hi, 32'h0000_AAAA);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // MADD (or its absence)
    cycle(1'b1, 3'd4, 32'h0, 32'd0);
    cycle(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0);
`ifdef MD_MADD_EN
    run_op(3'd6, 32'd1, 32'd1);
    chk("madd_busy_cycles", busy_seen, 32'd5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
`else
    cycle(1'b1, 3'd6, 32'd1, 32'd1);
    chk("op6_stall", {31'd0, last_stall}, 32'd0);
    #1;
    chk("op6_busy", {31'd0, busy}, 32'd0);
    chk("op6_hi", hi, 32'h0);
    chk("op6_lo", lo, 32'hFFFF_FFFF);
`endif
    cycle(1'b1, 3'd7, 32'd3, 32'd3);
    chk("op7_stall", {31'd0, last_stall}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), pick(), pick());
    end
    wait_done();

    // Reset mid-flight
    cycle(1'b1, 3'd4, 32'd5, 32'd0);
    cycle(1'b1, 3'd5, 32'd6, 32'd0);
    cycle(1'b1, 3'd0, 32'd3, 32'd4);
    cycle(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) cycle(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("post_rst_lo", lo, 32'h0);
    chk("post_rst_hi", hi, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- EX-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the operands and decoded op that the ID/EX pipeline register presents after the register latches them.
- Holds the architectural HI/LO registers.
- Produces the busy/stall request that the hazard logic converts into the `stop` bubble-insert input of the ID/EX register.

Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update (>=1)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  op valid this cycle (EX-stage instruction is an md op)
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (optional), 7 reserved
- a  input  32  rs operand (forwarded RS value)
- b  input  32  rt operand (forwarded RT value)
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  registered; 1 while a mult/div is in flight
- stall_req  output  1  combinational: busy | (start & op in {0,1,2,3,6})

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, counter=0, state IDLE, operand latches=0.
- FSM has two states, IDLE and BUSY.
- IDLE, start & op in {MULT,MULTU,DIV,DIVU,MADD}:
  - latch a, b, op;
  - load counter with MULT_CYCLES (for MULT/MULTU/MADD) or DIV_CYCLES (for DIV/DIVU);
  - go to BUSY; busy=1 from the next cycle.
- BUSY: counter decrements every cycle.
- When counter==1, at that clock edge:
  - write hi/lo;
  - busy=0;
  - return to IDLE.
- Total latency: edge of acceptance + N edges. Results are visible N cycles after the start cycle.
- MULT: {hi,lo} = signed 32x32 -> 64. MULTU: unsigned.
- DIV: lo = signed quotient (truncate toward zero), hi = remainder (same sign as dividend). DIVU: unsigned.
- Divide by zero (b==0): the op still occupies DIV_CYCLES, and hi/lo are left unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE: hi or lo takes a on the next edge. They are single-cycle, busy stays 0 and stall_req=0.
- start while busy: ignored; the operation is neither latched nor queued. The hazard logic guarantees the instruction is held via stall_req.
- MTHI/MTLO while busy: ignored. They are stalled upstream the same way.
- op 7, or op 6 with MD_MADD_EN undefined: no effect, no busy.
- hi/lo are readable at any time. While busy they show the pre-operation values. The hazard logic stalls MFHI/MFLO while stall_req=1.
- Reset asserted mid-operation: aborts immediately. No writeback; outputs go to reset values.
- Operand latches are captured only at acceptance. a/b changes during BUSY have no effect.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: op 6 (MADD) is accepted with MULT_CYCLES latency, and {hi,lo} <= {hi,lo} + signed(a*b), with 64-bit wrap-around.
- Undefined: op 6 is treated as a no-op and stall_req does not assert for it.

Decomposition:
- Shared package/include (alongside the existing control-define include) holds:
  - op encodings MD_MULT..MD_MADD (3-bit constants);
  - state encodings IDLE/BUSY;
  - default cycle counts.
- One natural sub-module: md_alu, purely combinational. Its inputs are the latched a, b, op and the current hi/lo; its output is the 64-bit {hi_next, lo_next}.
- md_unit keeps the FSM, counter and registers.

Test Plan:
- Reset mid-flight: start MULT 3x4, assert reset at cycle 2 -> hi=lo=0, busy=0 immediately; no later writeback.
- MULT 0xFFFFFFFF x 2, start 1 cycle:
  - busy=1 for cycles 1-5;
  - stall_req=1 in the start cycle and during busy;
  - at cycle 5 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV 5/0 after MTLO 0x1234 -> busy for 10 cycles, then lo stays 0x1234 and hi unchanged.
- Busy contention:
  - DIVU 100/7 started, then start MTHI 0xAAAA at cycle 3 -> ignored;
  - at cycle 10 lo=14, hi=2;
  - a subsequent MTHI 0xAAAA in IDLE gives hi=0xAAAA next cycle with no busy.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADD 1x1 -> after 5 cycles hi=1, lo=0.
- Without MD_MADD_EN: op 6 -> no change, stall_req=0.
